// File: rtl/frame_pkg.sv
// Shared constants and types for the input framing stage and its overlap-add counterpart.
package frame_pkg;

    localparam int SAMPLE_W     = 12;
    localparam int HOP_LOG2_DEF = 10;
    localparam int HOP_LEN      = 1 << HOP_LOG2_DEF;
    localparam int FRAME_LEN    = 2 * HOP_LEN;
    localparam int NUM_BANKS    = 3;

    // Sideband layout of fft_user: beat index in [10:0], bit 10 flags the newest hop.
    localparam int USER_W        = 12;
    localparam int USER_IDX_W    = 11;
    localparam int USER_HALF_BIT = 10;

    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        WARMUP2 = 2'd1,
        IDLE    = 2'd2,
        EMIT    = 2'd3
    } state_t;

    typedef logic [1:0] bank_t;

    function automatic bank_t bank_inc(input bank_t b);
        return (b == 2'd2) ? 2'd0 : b + 2'd1;
    endfunction

    function automatic bank_t bank_dec(input bank_t b);
        return (b == 2'd0) ? 2'd2 : b - 2'd1;
    endfunction

endpackage

// File: rtl/frame_bank_mem.sv
// Simple dual-port sample store: one write port, one read port with a registered read.
module frame_bank_mem
    import frame_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int ADDR_W = HOP_LOG2_DEF + 2,
    parameter int DEPTH  = NUM_BANKS * HOP_LEN
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_overlap_split.sv
// Captures hops of audio samples into a rotating three-bank store and streams
// 50%-overlapped frames (previous hop, then newest hop) towards the forward FFT.
module frame_overlap_split
    import frame_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_W,
    parameter int HOP_LOG2     = HOP_LOG2_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    output logic [31:0]             fft_data,
    output logic [HOP_LOG2+1:0]     fft_user,
    output logic                    fft_valid,
    input  logic                    fft_ready,
    output logic                    fft_last,
    output logic                    frame_overrun
);

    localparam int IDX_W  = HOP_LOG2 + 1;
    localparam int ADDR_W = HOP_LOG2 + 2;
    localparam int DEPTH  = NUM_BANKS << HOP_LOG2;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    // Capture side
    bank_t               wb_q, wb_d;
    logic [HOP_LOG2-1:0] wi_q, wi_d;
    logic                hop_done;

    // Read side
    state_t              state_q;
    logic                frame_overrun_q;
    logic                start;
    logic                rd_en;
    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
    logic                rd_active_q, rd_active_d;
    bank_t               lo_bank_q, lo_bank_d;
    bank_t               hi_bank_q, hi_bank_d;
    bank_t               rd_bank;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_vld_q, rd_vld_d;
    logic [IDX_W-1:0]    rd_tag_q, rd_tag_d;
    logic [SAMPLE_WIDTH-1:0] mem_rd_data;

    // Two-entry skid buffer; entry 0 drives the outputs
    logic [1:0]              cnt_q, cnt_d;
    logic [SAMPLE_WIDTH-1:0] ent0_data_q, ent0_data_d;
    logic [SAMPLE_WIDTH-1:0] ent1_data_q, ent1_data_d;
    logic [IDX_W-1:0]        ent0_idx_q, ent0_idx_d;
    logic [IDX_W-1:0]        ent1_idx_q, ent1_idx_d;
    logic                    push, pop, space_ok;
    logic [2:0]              occ;

    frame_bank_mem #(
        .DATA_W (SAMPLE_WIDTH),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (sample_valid),
        .wr_addr ({wb_q, wi_q}),
        .wr_data (sample_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (mem_rd_data)
    );

    always_comb begin
        hop_done = sample_valid && (wi_q == '1);
        wi_d     = wi_q;
        wb_d     = wb_q;
        if (sample_valid) begin
            wi_d = wi_q + 1'b1;
            if (hop_done) begin
                wb_d = bank_inc(wb_q);
            end
        end
    end

    // The first read is issued in the hop_done cycle itself so the first beat
    // appears two cycles after the final sample strobe.
    always_comb begin
        pop      = (cnt_q != 2'd0) && fft_ready;
        push     = rd_vld_q;
        occ      = {1'b0, cnt_q} + {2'b00, rd_vld_q};
        // A new read lands in the buffer two cycles later; only issue it if a slot is guaranteed.
        space_ok = pop ? (occ <= 3'd2) : (occ <= 3'd1);
        start    = hop_done && ((state_q == WARMUP2) || (state_q == IDLE));
        rd_en    = start || ((state_q == EMIT) && rd_active_q && space_ok);
        rd_idx   = start ? '0 : rd_idx_q;

        if (start) begin
            rd_bank = bank_dec(wb_q);
        end else begin
            rd_bank = rd_idx_q[IDX_W-1] ? hi_bank_q : lo_bank_q;
        end
        rd_addr = {rd_bank, rd_idx[HOP_LOG2-1:0]};

        rd_idx_d    = rd_idx_q;
        rd_active_d = rd_active_q;
        lo_bank_d   = lo_bank_q;
        hi_bank_d   = hi_bank_q;
        if (start) begin
            lo_bank_d = bank_dec(wb_q);
            hi_bank_d = wb_q;
        end
        if (rd_en) begin
            rd_idx_d    = rd_idx + 1'b1;
            rd_active_d = (rd_idx != LAST_IDX);
        end
        rd_vld_d = rd_en;
        rd_tag_d = rd_idx;
    end

    always_comb begin
        cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};
        ent0_data_d = ent0_data_q;
        ent0_idx_d  = ent0_idx_q;
        ent1_data_d = ent1_data_q;
        ent1_idx_d  = ent1_idx_q;
        if (pop) begin
            ent0_data_d = ent1_data_q;
            ent0_idx_d  = ent1_idx_q;
        end
        if (push) begin
            if ((cnt_q - {1'b0, pop}) == 2'd0) begin
                ent0_data_d = mem_rd_data;
                ent0_idx_d  = rd_tag_q;
            end else begin
                ent1_data_d = mem_rd_data;
                ent1_idx_d  = rd_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q        <= '0;
            wi_q        <= '0;
            rd_idx_q    <= '0;
            rd_active_q <= 1'b0;
            lo_bank_q   <= '0;
            hi_bank_q   <= '0;
            rd_vld_q    <= 1'b0;
            rd_tag_q    <= '0;
            cnt_q       <= '0;
            ent0_data_q <= '0;
            ent0_idx_q  <= '0;
            ent1_data_q <= '0;
            ent1_idx_q  <= '0;
        end else begin
            wb_q        <= wb_d;
            wi_q        <= wi_d;
            rd_idx_q    <= rd_idx_d;
            rd_active_q <= rd_active_d;
            lo_bank_q   <= lo_bank_d;
            hi_bank_q   <= hi_bank_d;
            rd_vld_q    <= rd_vld_d;
            rd_tag_q    <= rd_tag_d;
            cnt_q       <= cnt_d;
            ent0_data_q <= ent0_data_d;
            ent0_idx_q  <= ent0_idx_d;
            ent1_data_q <= ent1_data_d;
            ent1_idx_q  <= ent1_idx_d;
        end
    end

    // A hop finishing mid-emission drops that frame; the current one runs to completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= WARMUP;
            frame_overrun_q <= 1'b0;
        end else begin
            frame_overrun_q <= 1'b0;
            case (state_q)
                WARMUP: begin
                    if (hop_done) state_q <= WARMUP2;
                end
                WARMUP2, IDLE: begin
                    if (hop_done) state_q <= EMIT;
                end
                EMIT: begin
                    if (hop_done) frame_overrun_q <= 1'b1;
                    if (pop && fft_last) state_q <= IDLE;
                end
                default: state_q <= WARMUP;
            endcase
        end
    end

    assign fft_valid     = (cnt_q != 2'd0);
    assign fft_data      = {16'h0000, {(16-SAMPLE_WIDTH){ent0_data_q[SAMPLE_WIDTH-1]}}, ent0_data_q};
    assign fft_user      = {1'b0, ent0_idx_q};
    assign fft_last      = fft_valid && (ent0_idx_q == LAST_IDX);
    assign frame_overrun = frame_overrun_q;

endmodule

// File: tb/tb_frame_overlap_split.sv
// Randomized bench for frame_overlap_split with a sample-history reference model.
module tb_frame_overlap_split;
    import frame_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic [31:0] fft_data;
    logic [11:0] fft_user;
    logic        fft_valid;
    logic        fft_ready = 1'b0;
    logic        fft_last;
    logic        frame_overrun;

    always #5 clk = ~clk;

    frame_overlap_split #(.SAMPLE_WIDTH(12), .HOP_LOG2(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .fft_data      (fft_data),
        .fft_user      (fft_user),
        .fft_valid     (fft_valid),
        .fft_ready     (fft_ready),
        .fft_last      (fft_last),
        .frame_overrun (frame_overrun)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [11:0] user;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [11:0] hist[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  busy = 1'b0;
    bit  cur_dc = 1'b0;
    int  exp_ovr = 0;
    int  seen_ovr = 0;
    int  beat_cnt = 0;
    int  ready_mode = 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: every completed hop h>=2 yields a frame of samples (h-2)*HOP_LEN .. h*HOP_LEN-1.
    task automatic model_sample(input logic [11:0] s);
        int    h;
        int    v;
        beat_t b;
        hist.push_back(s);
        if (hist.size() % HOP_LEN == 0) begin
            h = hist.size() / HOP_LEN;
            if (h >= 2) begin
                if (busy) begin
                    exp_ovr++;
                    cur_dc = 1'b1;
                end else begin
                    busy     = 1'b1;
                    beat_cnt = 0;
                    for (int k = 0; k < FRAME_LEN; k++) begin
                        v = $signed(hist[(h - 2) * HOP_LEN + k]);
                        b.data = {16'h0000, v[15:0]};
                        b.user = '0;
                        b.user[USER_IDX_W-1:0] = USER_IDX_W'(k);
                        b.last = (k == FRAME_LEN - 1);
                        exp_q.push_back(b);
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    beat_t mon_cur;
    beat_t mon_prev;
    beat_t mon_exp;
    bit    mon_hold = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            mon_cur = {fft_data, fft_user, fft_last};
            if (rst) begin
                mon_hold = 1'b0;
            end else begin
                if (frame_overrun) seen_ovr++;
                if (mon_hold) begin
                    check("hold_valid", 64'(fft_valid), 64'd1);
                    check("hold_beat", 64'(mon_cur), 64'(mon_prev));
                end
                if (fft_valid && fft_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_beat", 64'(mon_cur), 64'd0);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (!cur_dc) check("beat_data", 64'(fft_data), 64'(mon_exp.data));
                        check("beat_user_last", 64'({fft_user, fft_last}), 64'({mon_exp.user, mon_exp.last}));
                        check("user_half", 64'(fft_user[USER_HALF_BIT]), 64'(beat_cnt >= HOP_LEN));
                        beat_cnt++;
                        if (mon_exp.last) begin
                            busy   = 1'b0;
                            cur_dc = 1'b0;
                        end
                    end
                end
                mon_hold = fft_valid && !fft_ready;
                mon_prev = mon_cur;
            end
        end
    end

    task automatic tick(input bit sv, input logic [11:0] s);
        @(posedge clk);
        #1;
        sample_valid = sv;
        sample_in    = sv ? s : 12'd0;
        case (ready_mode)
            0:       fft_ready = 1'b0;
            1:       fft_ready = 1'b1;
            default: fft_ready = ($urandom_range(0, 9) < 3);
        endcase
        if (sv) model_sample(s);
    endtask

    task automatic feed(input int count, input int mode, input logic [11:0] base);
        logic [11:0] s;
        for (int i = 0; i < count; i++) begin
            case (mode)
                0:       s = base + 12'(i);
                1:       s = base;
                default: s = 12'($urandom);
            endcase
            tick(1'b1, s);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 20000) begin
            tick(1'b0, 12'd0);
            n++;
        end
        check("drain_done", 64'(busy || exp_q.size() != 0), 64'd0);
        exp_q.delete();
        busy   = 1'b0;
        cur_dc = 1'b0;
        repeat (4) tick(1'b0, 12'd0);
        check("idle_no_valid", 64'(fft_valid), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst          = 1'b1;
        sample_valid = 1'b0;
        hist.delete();
        exp_q.delete();
        busy   = 1'b0;
        cur_dc = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", 64'(fft_valid), 64'd0);
        check("rst_last", 64'(fft_last), 64'd0);
        check("rst_data", 64'(fft_data), 64'd0);
        check("rst_user", 64'(fft_user), 64'd0);
        check("rst_overrun", 64'(frame_overrun), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_last;
        int n;
        int ovr0;
        int eovr0;

        repeat (3) @(posedge clk);
        do_reset();

        // Ramp: first frame latency and contents, then the overlapping second frame
        ready_mode = 1;
        feed(FRAME_LEN - 1, 0, 12'd0);
        tick(1'b1, 12'd2047);
        t_last = cyc;
        tick(1'b0, 12'd0);
        check("lat_t1_valid", 64'(fft_valid), 64'd0);
        tick(1'b0, 12'd0);
        check("lat_t2_valid", 64'(fft_valid), 64'd1);
        check("first_data", 64'(fft_data), 64'd0);
        check("first_user", 64'(fft_user), 64'd0);
        n = 0;
        while (!(fft_valid && fft_last) && n < 4000) begin
            tick(1'b0, 12'd0);
            n++;
        end
        check("last_latency", 64'(cyc - t_last), 64'd2049);
        wait_idle();
        feed(HOP_LEN, 0, 12'd2048);
        wait_idle();

        // Random backpressure at roughly 30% ready
        ready_mode = 2;
        feed(HOP_LEN, 2, 12'd0);
        wait_idle();
        feed(HOP_LEN, 2, 12'd0);
        wait_idle();

        // Sign extension: hop of 0x800 followed by hop of 0x7FF
        ready_mode = 1;
        feed(HOP_LEN, 1, 12'h800);
        wait_idle();
        feed(HOP_LEN - 1, 1, 12'h7FF);
        tick(1'b1, 12'h7FF);
        tick(1'b0, 12'd0);
        tick(1'b0, 12'd0);
        check("sign_neg_beat0", 64'(fft_data), 64'h0000_F800);
        wait_idle();

        // Overrun: stall across a full following hop
        ready_mode = 0;
        ovr0  = seen_ovr;
        eovr0 = exp_ovr;
        feed(HOP_LEN, 2, 12'd0);
        feed(HOP_LEN, 2, 12'd0);
        repeat (3) tick(1'b0, 12'd0);
        check("overrun_pulses", 64'(seen_ovr - ovr0), 64'(exp_ovr - eovr0));
        ready_mode = 1;
        wait_idle();
        feed(HOP_LEN, 2, 12'd0);
        wait_idle();
        check("overrun_total", 64'(seen_ovr), 64'(exp_ovr));

        // Reset in the middle of a frame, then a fresh two-hop warmup
        feed(HOP_LEN, 2, 12'd0);
        n = 0;
        while (beat_cnt < 500 && n < 3000) begin
            tick(1'b0, 12'd0);
            n++;
        end
        check("reached_beat_500", 64'(beat_cnt), 64'd500);
        do_reset();
        feed(FRAME_LEN - 1, 2, 12'd0);
        repeat (4) tick(1'b0, 12'd0);
        check("warmup_no_valid", 64'(fft_valid), 64'd0);
        feed(1, 2, 12'd0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
